sysbus_mem: RTL and testbench

- Word-addressed 64-bit system memory that sits directly downstream of cpu_core on the shared bus.
- Demultiplexes address and data from Sysbus using nALE.
- Services reads and writes strobed by nME/RnW/nOE.
- Returns read data on the core's Data_in input after a fixed, parameterised latency.
- Raises status flags used by the bench and by future wait-state logic.

---
 rtl/sysbus_mem_if.sv | 22 ++
 rtl/sysbus_mem.sv | 106 ++++++++++
 tb/tb_sysbus_mem.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sysbus_mem_if.sv
// rtl/sysbus_mem_if.sv - multiplexed address/data system bus between cpu_core and sysbus_mem
interface sysbus_mem_if;
    logic [63:0] Sysbus;
    logic        nALE;
    logic        nME;
    logic        RnW;
    logic        nOE;
    logic [63:0] Data_in;
    logic        RdValid;
    logic        Busy;
    logic        Err;

    modport master (
        output Sysbus, nALE, nME, RnW, nOE,
        input  Data_in, RdValid, Busy, Err
    );

    modport slave (
        input  Sysbus, nALE, nME, RnW, nOE,
        output Data_in, RdValid, Busy, Err
    );
endinterface

// File: rtl/sysbus_mem.sv
// rtl/sysbus_mem.sv - word-addressed 64-bit memory on the multiplexed system bus
module sysbus_mem #(
    parameter int ADDR_WIDTH = 10,
    parameter int ADDR_LSB   = 3,
    parameter int READ_LAT   = 2
) (
    input  logic          Clock,
    input  logic          nReset,
    sysbus_mem_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, ADDR, RD_WAIT, RD_DATA, WR_HOLD} state_t;

    state_t                state;
    state_t                state_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  oor_q;
    logic [3:0]            cnt;
    logic [63:0]           data_q;
    logic                  err_q;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  load_data;
    logic [63:0]           mem [DEPTH];

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_n;
    end

    // nALE low overrides every state so a new address always aborts the access in flight
    always_comb begin
        state_n   = state;
        rd_accept = 1'b0;
        wr_accept = 1'b0;
        load_data = 1'b0;
        if (!bus.nALE) begin
            state_n = ADDR;
        end else begin
            case (state)
                IDLE: state_n = IDLE;
                ADDR: begin
                    if (!bus.nME) begin
                        if (!bus.RnW) begin
                            wr_accept = 1'b1;
                            state_n   = WR_HOLD;
                        end else if (!bus.nOE) begin
                            rd_accept = 1'b1;
                            if (READ_LAT == 1) begin
                                load_data = 1'b1;
                                state_n   = RD_DATA;
                            end else begin
                                state_n   = RD_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (bus.nME) begin
                        state_n = IDLE;
                    end else if (cnt == 4'd1) begin
                        load_data = 1'b1;
                        state_n   = RD_DATA;
                    end
                end
                RD_DATA: if (bus.nME) state_n = IDLE;
                WR_HOLD: if (bus.nME) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            addr_q <= '0;
            oor_q  <= 1'b0;
            cnt    <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= (rd_accept | wr_accept) & oor_q;
            if (!bus.nALE) begin
                addr_q <= bus.Sysbus[ADDR_LSB +: ADDR_WIDTH];
                oor_q  <= |bus.Sysbus[63:ADDR_LSB+ADDR_WIDTH];
            end
            if (rd_accept)
                cnt <= 4'(READ_LAT - 1);
            else if (state == RD_WAIT)
                cnt <= cnt - 4'd1;
            if (load_data)
                data_q <= oor_q ? 64'd0 : mem[addr_q];
        end
    end

    // Array is deliberately left out of reset; a write is only taken from ADDR, never under reset
    always_ff @(posedge Clock) begin
        if (wr_accept && !oor_q)
            mem[addr_q] <= bus.Sysbus;
    end

    assign bus.Data_in = data_q;
    assign bus.RdValid = (state == RD_DATA) & ~bus.nOE;
    assign bus.Busy    = (state != IDLE);
    assign bus.Err     = err_q;
endmodule

// File: tb/tb_sysbus_mem.sv
// tb/tb_sysbus_mem.sv - self-checking bench for sysbus_mem at read latencies 1, 2 and 5
module tb_sysbus_mem;
    localparam int AW  = 10;
    localparam int LSB = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] sysbus = 64'd0;
    logic        n_ale = 1'b1;
    logic        n_me = 1'b1;
    logic        rnw = 1'b1;
    logic        n_oe = 1'b1;

    always #5 clk = ~clk;

    sysbus_mem_if b0 ();
    sysbus_mem_if b1 ();
    sysbus_mem_if b2 ();

    assign b0.Sysbus = sysbus; assign b0.nALE = n_ale; assign b0.nME = n_me; assign b0.RnW = rnw; assign b0.nOE = n_oe;
    assign b1.Sysbus = sysbus; assign b1.nALE = n_ale; assign b1.nME = n_me; assign b1.RnW = rnw; assign b1.nOE = n_oe;
    assign b2.Sysbus = sysbus; assign b2.nALE = n_ale; assign b2.nME = n_me; assign b2.RnW = rnw; assign b2.nOE = n_oe;

    sysbus_mem #(.ADDR_WIDTH(AW), .ADDR_LSB(LSB), .READ_LAT(1)) dut0 (.Clock(clk), .nReset(rst_n), .bus(b0));
    sysbus_mem #(.ADDR_WIDTH(AW), .ADDR_LSB(LSB), .READ_LAT(2)) dut1 (.Clock(clk), .nReset(rst_n), .bus(b1));
    sysbus_mem #(.ADDR_WIDTH(AW), .ADDR_LSB(LSB), .READ_LAT(5)) dut2 (.Clock(clk), .nReset(rst_n), .bus(b2));

    logic [63:0] dout [3];
    logic        rv   [3];
    logic        bsy  [3];
    logic        er   [3];

    always_comb begin
        dout[0] = b0.Data_in; rv[0] = b0.RdValid; bsy[0] = b0.Busy; er[0] = b0.Err;
        dout[1] = b1.Data_in; rv[1] = b1.RdValid; bsy[1] = b1.Busy; er[1] = b1.Err;
        dout[2] = b2.Data_in; rv[2] = b2.RdValid; bsy[2] = b2.Busy; er[2] = b2.Err;
    end

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk64(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act === exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s inst%0d: got %h expected %h at %0t", name, idx, act, exp, $time);
    endtask

    task automatic chk1(input string name, input int idx, input logic act, input logic exp);
        total = total + 1;
        if (act === exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s inst%0d: got %b expected %b at %0t", name, idx, act, exp, $time);
    endtask

    // Transaction-level model: an access opens on nALE, is accepted once by a strobe, and
    // read data becomes visible in the lat-th cycle after the accepting edge.
    int          lat_tab [3] = '{1, 2, 5};
    int          cyc = 0;
    bit          m_act   [3] = '{0, 0, 0};
    bit          m_acc   [3] = '{0, 0, 0};
    bit          m_rd    [3] = '{0, 0, 0};
    bit          m_rdy   [3] = '{0, 0, 0};
    bit          m_err   [3] = '{0, 0, 0};
    bit          m_known [3] = '{1, 1, 1};
    logic [63:0] m_addr  [3];
    logic [63:0] m_data  [3] = '{64'd0, 64'd0, 64'd0};
    int          m_due   [3];
    logic [63:0] mem_m [int];

    function automatic bit is_oor(input logic [63:0] a);
        return (a >> (LSB + AW)) != 64'd0;
    endfunction

    function automatic int word_of(input logic [63:0] a);
        return int'((a >> LSB) % (64'd1 << AW));
    endfunction

    task automatic model_load(input int i);
        m_rdy[i] = 1'b1;
        if (is_oor(m_addr[i])) begin
            m_data[i] = 64'd0; m_known[i] = 1'b1;
        end else if (mem_m.exists(word_of(m_addr[i]))) begin
            m_data[i] = mem_m[word_of(m_addr[i])]; m_known[i] = 1'b1;
        end else begin
            m_known[i] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_act[i] = 0; m_acc[i] = 0; m_rdy[i] = 0; m_err[i] = 0;
                m_data[i] = 64'd0; m_known[i] = 1;
            end else begin
                m_err[i] = 0;
                if (!n_ale) begin
                    m_act[i] = 1; m_acc[i] = 0; m_rdy[i] = 0; m_addr[i] = sysbus;
                end else if (m_act[i] && !m_acc[i]) begin
                    if (!n_me && (!rnw || !n_oe)) begin
                        m_acc[i] = 1; m_rd[i] = rnw; m_err[i] = is_oor(m_addr[i]);
                        if (!rnw) begin
                            if (!is_oor(m_addr[i])) mem_m[word_of(m_addr[i])] = sysbus;
                        end else begin
                            m_due[i] = cyc + lat_tab[i] - 1;
                            if (cyc == m_due[i]) model_load(i);
                        end
                    end
                end else if (m_act[i]) begin
                    if (n_me) begin
                        m_act[i] = 0; m_rdy[i] = 0;
                    end else if (m_rd[i] && !m_rdy[i] && cyc == m_due[i]) begin
                        model_load(i);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk1("busy", i, bsy[i], m_act[i]);
            chk1("rdvalid", i, rv[i], m_rdy[i] & m_act[i] & ~n_oe);
            chk1("err", i, er[i], m_err[i]);
            if (m_known[i]) chk64("data", i, dout[i], m_data[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [63:0] a, input logic [63:0] d);
        n_ale = 0; sysbus = a; tick();
        n_ale = 1; n_me = 0; rnw = 0; sysbus = d; tick();
        sysbus = ~d; tick();
        n_me = 1; rnw = 1; sysbus = 64'd0; tick();
        tick();
    endtask

    task automatic bus_read(input logic [63:0] a, input int hold);
        n_ale = 0; sysbus = a; tick();
        n_ale = 1; n_me = 0; rnw = 1; n_oe = 0; sysbus = 64'd0;
        repeat (hold) tick();
        n_me = 1; n_oe = 1; tick();
        tick();
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1; tick();
        for (int i = 0; i < 3; i++) begin
            chk64("rst_data", i, dout[i], 64'd0);
            chk1("rst_busy", i, bsy[i], 1'b0);
        end

        bus_write(64'h40, 64'hDEADBEEF_CAFEF00D);
        n_ale = 0; sysbus = 64'h40; tick();
        n_ale = 1; n_me = 0; rnw = 1; n_oe = 0; sysbus = 64'd0; tick(); #4;
        chk1("lat1_rv_c1", 0, rv[0], 1'b1);
        chk64("lat1_data", 0, dout[0], 64'hDEADBEEF_CAFEF00D);
        chk1("lat2_rv_c1", 1, rv[1], 1'b0);
        tick(); #4;
        chk1("lat2_rv_c2", 1, rv[1], 1'b1);
        chk64("lat2_data", 1, dout[1], 64'hDEADBEEF_CAFEF00D);
        chk64("model_pin", 1, m_data[1], 64'hDEADBEEF_CAFEF00D);
        chk1("lat2_err", 1, er[1], 1'b0);
        tick(); tick(); #4;
        chk1("lat5_rv_c4", 2, rv[2], 1'b0);
        tick(); #4;
        chk1("lat5_rv_c5", 2, rv[2], 1'b1);
        chk64("lat5_data", 2, dout[2], 64'hDEADBEEF_CAFEF00D);
        n_oe = 1; #1;
        chk1("noe_gate_rv", 1, rv[1], 1'b0);
        chk64("noe_gate_hold", 1, dout[1], 64'hDEADBEEF_CAFEF00D);
        tick();
        n_oe = 0; #1;
        chk1("noe_regate_rv", 1, rv[1], 1'b1);
        chk1("busy_before_end", 2, bsy[2], 1'b1);
        n_me = 1; n_oe = 1; tick();
        chk1("busy_after_end", 2, bsy[2], 1'b0);
        tick();

        bus_write(64'h0, 64'h01234567_89ABCDEF);
        n_ale = 0; sysbus = 64'h1_0000_0000; tick();
        n_ale = 1; n_me = 0; rnw = 0; sysbus = 64'h55; tick();
        chk1("oor_wr_err", 1, er[1], 1'b1);
        tick();
        chk1("oor_wr_err_end", 1, er[1], 1'b0);
        n_me = 1; rnw = 1; sysbus = 64'd0; tick(); tick();
        bus_read(64'h1_0000_0000, 6);
        chk64("oor_rd_zero", 2, dout[2], 64'd0);
        bus_read(64'h0, 6);
        for (int i = 0; i < 3; i++) chk64("mem0_kept", i, dout[i], 64'h01234567_89ABCDEF);

        bus_write(64'h80, 64'hAAAA0000_00000080);
        bus_write(64'h88, 64'hBBBB0000_00000088);
        n_ale = 0; sysbus = 64'h80; tick();
        n_ale = 1; n_me = 0; rnw = 1; n_oe = 0; sysbus = 64'd0; tick(); tick();
        chk1("abort_rv_pre", 2, rv[2], 1'b0);
        n_ale = 0; sysbus = 64'h88; tick();
        n_ale = 1; sysbus = 64'd0;
        chk1("abort_rv_post", 2, rv[2], 1'b0);
        chk64("abort_data_kept", 2, dout[2], 64'h01234567_89ABCDEF);
        repeat (5) tick(); #4;
        chk1("abort_new_rv", 2, rv[2], 1'b1);
        chk64("abort_new_data", 2, dout[2], 64'hBBBB0000_00000088);
        n_me = 1; n_oe = 1; tick(); tick();

        bus_write(64'h10, 64'h1111);
        n_ale = 0; sysbus = 64'h10; tick();
        n_ale = 1; n_me = 0; rnw = 0; sysbus = 64'h1234; #5;
        rst_n = 0; #1;
        for (int i = 0; i < 3; i++) begin
            chk64("rst_mid_data", i, dout[i], 64'd0);
            chk1("rst_mid_busy", i, bsy[i], 1'b0);
            chk1("rst_mid_rv", i, rv[i], 1'b0);
            chk1("rst_mid_err", i, er[i], 1'b0);
        end
        tick();
        rst_n = 1; n_me = 1; rnw = 1; sysbus = 64'd0; tick();
        n_me = 0; n_oe = 0; tick(); tick();
        chk1("idle_strobe_ignored", 1, bsy[1], 1'b0);
        n_me = 1; n_oe = 1; tick();
        bus_read(64'h10, 6);
        for (int i = 0; i < 3; i++) chk64("rst_write_dropped", i, dout[i], 64'h1111);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
